weight_sweep_sequencer: RTL and testbench
=========================================

Name: weight_sweep_sequencer

Overview:
- Synthesizable controller that sequences a combinational canonical_form circuit under test through an exhaustive input sweep.
- For every var_inputs value, steps const_inputs through all 2^NUM_CONSTS codes and counts the 1s on each output, giving that output's weight.
- Emits one weight vector per var value over a valid/ready handshake.
- Lets on-chip or FPGA characterisation replace the software sweep loop; results feed the WEIGHT_MATRIX comparison logic downstream.

Parameters:
- NUM_CONSTS, 2, number of constant-select inputs of the swept circuit.
- NUM_VARS, 2, number of variable inputs of the swept circuit.
- NUM_OUTPUTS, 2, number of outputs of the swept circuit.
- Derived WW = NUM_CONSTS+1, width of one weight; holds values 0..2^NUM_CONSTS.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a full sweep; ignored unless IDLE.
- abort  in  1  synchronous abort; returns to IDLE from any state.
- const_inputs  out  NUM_CONSTS  drives the circuit's const inputs (registered).
- var_inputs  out  NUM_VARS  drives the circuit's var inputs (registered).
- dut_outputs  in  NUM_OUTPUTS  combinational outputs of the circuit.
- weight_valid  out  1  result beat available.
- weight_ready  in  1  consumer accepts the beat.
- weight_var  out  NUM_VARS  var value the beat belongs to.
- weight_data  out  NUM_OUTPUTS*WW  packed weights; output k occupies bits [k*WW +: WW].
- busy  out  1  high in SWEEP or EMIT.
- done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (async assert, sync deassert inside the block):
  - State = IDLE.
  - const_inputs, var_inputs, weight_var and weight_data = 0.
  - weight_valid, busy and done = 0.
  - All internal accumulators = 0.
- FSM states: IDLE, SWEEP, EMIT, FINISH.
- IDLE:
  - start=1 -> SWEEP.
  - const_inputs=0, var_inputs=0, accumulators cleared.
- SWEEP, each cycle:
  - acc[k] += dut_outputs[k] for every k. The sample is taken in the same cycle the registered const/var values are presented; the circuit is combinational, so there is no wait state.
  - If const_inputs != 2^NUM_CONSTS-1, const_inputs increments.
  - Otherwise go to EMIT. The final increment is folded in, so weight_data = acc including the last sample.
  - Exactly 2^NUM_CONSTS sample cycles occur per var value.
- EMIT:
  - weight_valid=1.
  - weight_data and weight_var stay stable until weight_valid && weight_ready.
  - On handshake, if var_inputs != 2^NUM_VARS-1: var_inputs++, const_inputs=0, accumulators cleared, go to SWEEP.
  - On handshake when var_inputs is at its maximum: go to FINISH.
- FINISH:
  - done=1 for exactly one cycle, then IDLE.
  - var_inputs and const_inputs return to 0 on the IDLE entry.
- Latency: with weight_ready held 1, start to done = 2^NUM_VARS*(2^NUM_CONSTS+1)+1 cycles.
  - start seen at edge 0.
  - First sample in the cycle after.
  - Each EMIT lasts ≥1 cycle.
- Boundary conditions:
  - Weight saturation cannot occur. WW bits hold 2^NUM_CONSTS, e.g. all-ones output with NUM_CONSTS=2 gives weight 4 = 3'b100.
  - weight_ready may be held high before valid; the handshake completes in the first EMIT cycle.
  - Back-pressure: weight_ready=0 stalls in EMIT indefinitely. const_inputs and var_inputs stay frozen; no accumulation happens.
  - start while busy is ignored; it causes no restart.
  - start in the same cycle as FINISH is ignored. A new sweep needs start in IDLE.
  - abort has priority over everything:
    - Next state is IDLE.
    - weight_valid drops next cycle.
    - No done pulse.
    - Accumulators cleared.
  - reset_n low mid-sweep immediately forces the reset values; no partial result is emitted.
  - NUM_VARS wrap: var_inputs never wraps past its maximum. The FINISH transition happens instead.

Test Plan:
- Bench model: NUM_CONSTS=2, NUM_VARS=1, NUM_OUTPUTS=2. dut_outputs[0]=const_inputs[0]; dut_outputs[1]=var_inputs[0]&(const_inputs==3).
  - start with ready=1 -> beat var=0 with weights {o1=0,o0=2}, then beat var=1 with {o1=1,o0=2}.
  - done pulses exactly 11 cycles after start.
- All-ones model (dut_outputs=2'b11) -> every beat has weights {4,4} (3'b100 each); this checks the full-count width.
- weight_ready=0 for 5 cycles during the first EMIT -> weight_valid is held and weight_data is unchanged. const_inputs and var_inputs stay frozen, and the sweep resumes correctly with the final beats matching the first test.
- abort asserted on the 2nd SWEEP cycle -> IDLE next cycle, no beats, no done. A subsequent start produces results identical to the first test.
- reset_n dropped mid-EMIT -> all outputs 0 asynchronously. After release and a start, the full correct sequence is produced.
- start pulsed while busy -> ignored; beat count stays at 2^NUM_VARS and only one done pulse occurs.

Source files
------------

// File: rtl/weight_sweep_sequencer_if.sv
// Sweep control, circuit-drive and weight-result signals of weight_sweep_sequencer.
// master = sequencer side, slave = circuit/consumer side.
interface weight_sweep_sequencer_if #(
   parameter int NUM_CONSTS  = 2,
   parameter int NUM_VARS    = 2,
   parameter int NUM_OUTPUTS = 2
);
   localparam int WW = NUM_CONSTS + 1;

   logic                        start;
   logic                        abort;
   logic [NUM_CONSTS-1:0]       const_inputs;
   logic [NUM_VARS-1:0]         var_inputs;
   logic [NUM_OUTPUTS-1:0]      dut_outputs;
   logic                        weight_valid;
   logic                        weight_ready;
   logic [NUM_VARS-1:0]         weight_var;
   logic [NUM_OUTPUTS*WW-1:0]   weight_data;
   logic                        busy;
   logic                        done;

   modport master (
      input  start, abort, dut_outputs, weight_ready,
      output const_inputs, var_inputs, weight_valid, weight_var, weight_data, busy, done
   );

   modport slave (
      output start, abort, dut_outputs, weight_ready,
      input  const_inputs, var_inputs, weight_valid, weight_var, weight_data, busy, done
   );
endinterface

// File: rtl/weight_sweep_sequencer.sv
// Exhaustive const/var sweep of a combinational circuit; one weight beat per var value,
// 2^NUM_CONSTS+1 cycles per beat with ready high. weight_ready low freezes the sweep in EMIT.
module weight_sweep_sequencer #(
   parameter int NUM_CONSTS  = 2,
   parameter int NUM_VARS    = 2,
   parameter int NUM_OUTPUTS = 2
) (
   input  logic                     clock,
   input  logic                     reset_n,
   weight_sweep_sequencer_if.master bus
);
   localparam int WW = NUM_CONSTS + 1;
   localparam logic [NUM_CONSTS-1:0] CONST_MAX = '1;
   localparam logic [NUM_VARS-1:0]   VAR_MAX   = '1;
   localparam logic [NUM_CONSTS-1:0] CONST_ONE = NUM_CONSTS'(1);
   localparam logic [NUM_VARS-1:0]   VAR_ONE   = NUM_VARS'(1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SWEEP  = 2'd1,
      ST_EMIT   = 2'd2,
      ST_FINISH = 2'd3
   } state_e;

   // Reset asserts asynchronously but releases on a clock edge.
   logic [1:0] rst_sync_q;
   logic [1:0] rst_sync_d;
   logic       rst_n_int;

   always_comb begin
      rst_sync_d = {rst_sync_q[0], 1'b1};
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= rst_sync_d;
      end
   end

   assign rst_n_int = rst_sync_q[1];

   state_e                              state_q, state_d;
   logic [NUM_CONSTS-1:0]               const_q, const_d;
   logic [NUM_VARS-1:0]                 var_q, var_d;
   logic [NUM_OUTPUTS-1:0][WW-1:0]      acc_q, acc_d;

   always_comb begin
      state_d = state_q;
      const_d = const_q;
      var_d   = var_q;
      acc_d   = acc_q;

      case (state_q)
         ST_IDLE: begin
            const_d = '0;
            var_d   = '0;
            acc_d   = '0;
            if (bus.start) begin
               state_d = ST_SWEEP;
            end
         end

         ST_SWEEP: begin
            // Current registered const/var are on the circuit now; its output is this cycle's sample.
            for (int k = 0; k < NUM_OUTPUTS; k++) begin
               acc_d[k] = acc_q[k] + WW'(bus.dut_outputs[k]);
            end
            if (const_q != CONST_MAX) begin
               const_d = const_q + CONST_ONE;
            end else begin
               state_d = ST_EMIT;
            end
         end

         ST_EMIT: begin
            if (bus.weight_ready) begin
               if (var_q != VAR_MAX) begin
                  var_d   = var_q + VAR_ONE;
                  const_d = '0;
                  acc_d   = '0;
                  state_d = ST_SWEEP;
               end else begin
                  state_d = ST_FINISH;
               end
            end
         end

         ST_FINISH: begin
            const_d = '0;
            var_d   = '0;
            acc_d   = '0;
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (bus.abort) begin
         state_d = ST_IDLE;
         const_d = '0;
         var_d   = '0;
         acc_d   = '0;
      end
   end

   always_ff @(posedge clock or negedge rst_n_int) begin
      if (!rst_n_int) begin
         state_q <= ST_IDLE;
         const_q <= '0;
         var_q   <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         const_q <= const_d;
         var_q   <= var_d;
         acc_q   <= acc_d;
      end
   end

   // Accumulators hold still in EMIT, so they double as the stable result payload.
   assign bus.const_inputs = const_q;
   assign bus.var_inputs   = var_q;
   assign bus.weight_var   = var_q;
   assign bus.weight_data  = acc_q;
   assign bus.weight_valid = (state_q == ST_EMIT);
   assign bus.busy         = (state_q == ST_SWEEP) || (state_q == ST_EMIT);
   assign bus.done         = (state_q == ST_FINISH);

endmodule

// File: tb/tb_weight_sweep_sequencer.sv
// Self-checking bench: the swept circuit is a lookup table, expected weights are popcounts over it.
module tb_weight_sweep_sequencer;
   localparam int NC = 2;
   localparam int NV = 1;
   localparam int NO = 2;

   logic clock;
   logic reset_n;
   int   checks;
   int   errors;

   weight_sweep_sequencer_if #(.NUM_CONSTS(NC), .NUM_VARS(NV), .NUM_OUTPUTS(NO)) bus ();

   weight_sweep_sequencer #(.NUM_CONSTS(NC), .NUM_VARS(NV), .NUM_OUTPUTS(NO)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   logic [1:0] tt [0:7];
   assign bus.dut_outputs = tt[{bus.var_inputs, bus.const_inputs}];

   initial clock = 1'b0;
   always #5 clock = ~clock;

   logic [0:0] beat_var_q [$];
   logic [5:0] beat_dat_q [$];
   logic [9:0] snap_q [$];
   int         done_cnt;
   int         done_at;
   bit         timeout;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [5:0] model_weights(input int v);
      int n0, n1;
      n0 = 0;
      n1 = 0;
      for (int c = 0; c < 4; c++) begin
         n0 += int'(tt[v*4 + c][0]);
         n1 += int'(tt[v*4 + c][1]);
      end
      return {3'(n1), 3'(n0)};
   endfunction

   task automatic load_plan_tt();
      for (int i = 0; i < 8; i++) begin
         tt[i][0] = ((i % 4) % 2) == 1;
         tt[i][1] = (i / 4 == 1) && (i % 4 == 3);
      end
   endtask

   // Pulses start, then runs cycle by cycle recording accepted beats and done pulses.
   task automatic run_collect(input int stall_n, input bit rand_rdy, input bit poke_start);
      int stall_left;
      beat_var_q.delete();
      beat_dat_q.delete();
      snap_q.delete();
      done_cnt   = 0;
      done_at    = -1;
      timeout    = 1'b0;
      stall_left = stall_n;
      bus.start  = 1'b1;
      tick();
      bus.start  = 1'b0;
      for (int cyc = 1; cyc < 400; cyc++) begin
         if (bus.done) begin
            done_cnt++;
            if (done_at < 0) done_at = cyc;
         end
         if (done_at >= 0 && cyc > done_at + 4) break;
         bus.start = poke_start && (cyc == 3 || cyc == 6 || cyc == done_at);
         if (bus.weight_valid && beat_var_q.size() == 0 && stall_left > 0) begin
            bus.weight_ready = 1'b0;
            stall_left--;
            snap_q.push_back({bus.const_inputs, bus.var_inputs, bus.weight_var, bus.weight_data});
         end else begin
            bus.weight_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         if (bus.weight_valid && bus.weight_ready) begin
            beat_var_q.push_back(bus.weight_var);
            beat_dat_q.push_back(bus.weight_data);
         end
         tick();
      end
      if (done_at < 0) timeout = 1'b1;
      bus.start        = 1'b0;
      bus.weight_ready = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b1;
      #2;
      reset_n = 1'b0;
      #3;
      checks++;
      if ({bus.const_inputs, bus.var_inputs, bus.weight_valid, bus.weight_var,
           bus.weight_data, bus.busy, bus.done} !== 13'd0) begin
         errors++;
         $display("FAIL reset_during: outputs=%b required all zero",
                  {bus.const_inputs, bus.var_inputs, bus.weight_valid, bus.weight_var,
                   bus.weight_data, bus.busy, bus.done});
      end
      repeat (3) tick();
      reset_n = 1'b1;
      repeat (4) tick();
      checks++;
      if ({bus.weight_valid, bus.busy, bus.done, bus.weight_data} !== 9'd0) begin
         errors++;
         $display("FAIL reset_after: valid/busy/done/data=%b required 0",
                  {bus.weight_valid, bus.busy, bus.done, bus.weight_data});
      end
   endtask

   task automatic test_basic();
      logic [5:0] exp_plan [2];
      exp_plan[0] = 6'o02;
      exp_plan[1] = 6'o12;
      load_plan_tt();
      run_collect(0, 1'b0, 1'b0);
      checks++;
      if (timeout) begin errors++; $display("FAIL basic_timeout: no done seen"); end
      checks++;
      if (beat_dat_q.size() != 2) begin
         errors++; $display("FAIL basic_beats: got %0d required 2", beat_dat_q.size());
      end
      for (int i = 0; i < 2 && i < beat_dat_q.size(); i++) begin
         checks++;
         if (beat_var_q[i] !== 1'(i) || beat_dat_q[i] !== exp_plan[i]) begin
            errors++;
            $display("FAIL basic_beat%0d: var=%0d data=%o required var=%0d data=%o",
                     i, beat_var_q[i], beat_dat_q[i], i, exp_plan[i]);
         end
      end
      checks++;
      if (done_at != 11 || done_cnt != 1) begin
         errors++;
         $display("FAIL basic_done: at=%0d count=%0d required at=11 count=1", done_at, done_cnt);
      end
      checks++;
      if (bus.busy !== 1'b0 || bus.const_inputs !== 2'd0 || bus.var_inputs !== 1'd0) begin
         errors++;
         $display("FAIL basic_idle: busy=%b const=%0d var=%0d required 0 0 0",
                  bus.busy, bus.const_inputs, bus.var_inputs);
      end
   endtask

   task automatic test_all_ones();
      for (int i = 0; i < 8; i++) tt[i] = 2'b11;
      run_collect(0, 1'b0, 1'b0);
      checks++;
      if (timeout || beat_dat_q.size() != 2) begin
         errors++; $display("FAIL ones_beats: got %0d timeout=%0d required 2 0", beat_dat_q.size(), timeout);
      end
      for (int i = 0; i < beat_dat_q.size(); i++) begin
         checks++;
         if (beat_dat_q[i] !== 6'b100100) begin
            errors++; $display("FAIL ones_beat%0d: data=%b required 100100", i, beat_dat_q[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      load_plan_tt();
      run_collect(5, 1'b0, 1'b0);
      checks++;
      if (snap_q.size() != 5) begin
         errors++; $display("FAIL bp_stall_len: got %0d required 5", snap_q.size());
      end
      for (int i = 0; i < snap_q.size(); i++) begin
         checks++;
         if (snap_q[i] !== {2'b11, 1'b0, 1'b0, 6'o02}) begin
            errors++; $display("FAIL bp_frozen%0d: const/var/wvar/data=%b required 1100000010", i, snap_q[i]);
         end
      end
      checks++;
      if (beat_dat_q.size() != 2 || done_at != 16 || done_cnt != 1) begin
         errors++;
         $display("FAIL bp_resume: beats=%0d done_at=%0d done_cnt=%0d required 2 16 1",
                  beat_dat_q.size(), done_at, done_cnt);
      end
      for (int i = 0; i < beat_dat_q.size(); i++) begin
         checks++;
         if (beat_dat_q[i] !== model_weights(i)) begin
            errors++; $display("FAIL bp_beat%0d: data=%o required %o", i, beat_dat_q[i], model_weights(i));
         end
      end
   endtask

   task automatic test_abort();
      int seen;
      load_plan_tt();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      checks++;
      if ({bus.busy, bus.weight_valid, bus.const_inputs, bus.var_inputs, bus.weight_data} !== 11'd0) begin
         errors++;
         $display("FAIL abort_idle: busy/valid/const/var/data=%b required 0",
                  {bus.busy, bus.weight_valid, bus.const_inputs, bus.var_inputs, bus.weight_data});
      end
      seen = 0;
      for (int c = 0; c < 15; c++) begin
         if (bus.weight_valid || bus.done || bus.busy) seen++;
         tick();
      end
      checks++;
      if (seen != 0) begin
         errors++; $display("FAIL abort_quiet: activity cycles=%0d required 0", seen);
      end
      run_collect(0, 1'b0, 1'b0);
      checks++;
      if (beat_dat_q.size() != 2 || done_at != 11) begin
         errors++; $display("FAIL abort_rerun: beats=%0d done_at=%0d required 2 11", beat_dat_q.size(), done_at);
      end
      for (int i = 0; i < beat_dat_q.size(); i++) begin
         checks++;
         if (beat_dat_q[i] !== model_weights(i)) begin
            errors++; $display("FAIL abort_beat%0d: data=%o required %o", i, beat_dat_q[i], model_weights(i));
         end
      end
   endtask

   task automatic test_reset_mid_emit();
      int n;
      load_plan_tt();
      bus.weight_ready = 1'b0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      n = 0;
      while (!bus.weight_valid && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (!bus.weight_valid) begin
         errors++; $display("FAIL rst_emit_reach: valid=%b required 1", bus.weight_valid);
      end
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({bus.const_inputs, bus.var_inputs, bus.weight_valid, bus.weight_var,
           bus.weight_data, bus.busy, bus.done} !== 13'd0) begin
         errors++;
         $display("FAIL rst_emit_async: outputs=%b required all zero",
                  {bus.const_inputs, bus.var_inputs, bus.weight_valid, bus.weight_var,
                   bus.weight_data, bus.busy, bus.done});
      end
      bus.weight_ready = 1'b1;
      repeat (2) tick();
      reset_n = 1'b1;
      repeat (4) tick();
      checks++;
      if (bus.weight_valid !== 1'b0 || bus.busy !== 1'b0) begin
         errors++; $display("FAIL rst_emit_release: valid=%b busy=%b required 0 0", bus.weight_valid, bus.busy);
      end
      run_collect(0, 1'b0, 1'b0);
      checks++;
      if (beat_dat_q.size() != 2 || done_at != 11) begin
         errors++; $display("FAIL rst_emit_rerun: beats=%0d done_at=%0d required 2 11", beat_dat_q.size(), done_at);
      end
      for (int i = 0; i < beat_dat_q.size(); i++) begin
         checks++;
         if (beat_dat_q[i] !== model_weights(i)) begin
            errors++; $display("FAIL rst_emit_beat%0d: data=%o required %o", i, beat_dat_q[i], model_weights(i));
         end
      end
   endtask

   task automatic test_start_while_busy();
      load_plan_tt();
      run_collect(0, 1'b0, 1'b1);
      checks++;
      if (beat_dat_q.size() != 2 || done_cnt != 1 || done_at != 11) begin
         errors++;
         $display("FAIL busy_start: beats=%0d done_cnt=%0d done_at=%0d required 2 1 11",
                  beat_dat_q.size(), done_cnt, done_at);
      end
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++; $display("FAIL finish_start: busy=%b required 0", bus.busy);
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 8; i++) tt[i] = 2'($urandom_range(0, 3));
         run_collect(int'($urandom_range(0, 3)), 1'b1, 1'b0);
         checks++;
         if (timeout || beat_dat_q.size() != 2 || done_cnt != 1) begin
            errors++;
            $display("FAIL rand%0d_count: beats=%0d done_cnt=%0d timeout=%0d required 2 1 0",
                     r, beat_dat_q.size(), done_cnt, timeout);
         end
         for (int i = 0; i < beat_dat_q.size(); i++) begin
            checks++;
            if (beat_var_q[i] !== 1'(i) || beat_dat_q[i] !== model_weights(i)) begin
               errors++;
               $display("FAIL rand%0d_beat%0d: var=%0d data=%o required var=%0d data=%o",
                        r, i, beat_var_q[i], beat_dat_q[i], i, model_weights(i));
            end
         end
      end
   endtask

   initial begin
      checks           = 0;
      errors           = 0;
      bus.start        = 1'b0;
      bus.abort        = 1'b0;
      bus.weight_ready = 1'b1;
      load_plan_tt();
      test_reset();
      test_basic();
      test_all_ones();
      test_backpressure();
      test_abort();
      test_reset_mid_emit();
      test_start_while_busy();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
